// File: rtl/traffic_pkg.sv
// Shared lamp codes, fault-bit indices, FSM states and lamp-rule helpers
// for the traffic-light safety stage.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam int FLT_CODE     = 0;
    localparam int FLT_CONFLICT = 1;
    localparam int FLT_TRANS    = 2;
    localparam int FLT_STUCK    = 3;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } tsm_state_e;

    function automatic logic lamp_valid(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YELLOW) || (code == LAMP_GREEN);
    endfunction

    // Only legal one-hot pairs are judged here; malformed codes are the code check's job.
    function automatic logic bad_step(input logic [2:0] prev, input logic [2:0] cur);
        logic legal;
        legal = ((prev == LAMP_RED)    && (cur == LAMP_GREEN))  ||
                ((prev == LAMP_GREEN)  && (cur == LAMP_YELLOW)) ||
                ((prev == LAMP_YELLOW) && (cur == LAMP_RED));
        return lamp_valid(prev) && lamp_valid(cur) && (prev != cur) && !legal;
    endfunction

endpackage

// File: rtl/tsm_flash_gen.sv
// Fault flash timer: flash_on starts high on restart and toggles every FLASH_CYC cycles.
module tsm_flash_gen #(
    parameter int FLASH_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic flash_on
);

    localparam int CW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            flash_on <= 1'b1;
        end else if (restart) begin
            cnt_q    <= '0;
            flash_on <= 1'b1;
        end else if (cnt_q == CW'(FLASH_CYC - 1)) begin
            cnt_q    <= '0;
            flash_on <= ~flash_on;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety stage between the traffic controller and the lamps: latches faults and
// forces flashing yellow. Stuck-phase check is built only with TSM_STUCK_CHECK_EN.
module traffic_safety_monitor
    import traffic_pkg::*;
#(
    parameter int MAX_PHASE = 64,
    parameter int FLASH_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] street_a_in,
    input  logic       street_a_pri_in,
    input  logic [2:0] street_b_in,
    input  logic       street_b_pri_in,
    input  logic       fault_clr,
    output logic [2:0] street_a,
    output logic       street_a_pri_lamp,
    output logic [2:0] street_b,
    output logic       street_b_pri_lamp,
    output logic       fault,
    output logic [3:0] fault_code
);

    if (MAX_PHASE < 1 || FLASH_CYC < 1) begin : g_bad_param
        $error("traffic_safety_monitor: MAX_PHASE and FLASH_CYC must be >= 1");
    end

    tsm_state_e state_q, state_d;
    logic [2:0] a_q, b_q;
    logic [2:0] a_lamp_q, b_lamp_q;
    logic       a_pri_q, b_pri_q;
    logic [3:0] viol;
    logic       both_red, enter_fault, stuck, flash_on, pass;

    assign both_red = (street_a_in == LAMP_RED) && (street_b_in == LAMP_RED);

`ifdef TSM_STUCK_CHECK_EN
    localparam int PW = $clog2(MAX_PHASE + 1);
    logic [PW-1:0] phase_q;
    logic          changed;

    assign changed = (street_a_in != a_q) || (street_b_in != b_q);

    // Runs only while staying in MONITOR, so entry and exit both restart it from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase_q <= '0;
        else if (state_q != ST_MONITOR || state_d != ST_MONITOR || changed)
            phase_q <= '0;
        else if (phase_q != PW'(MAX_PHASE))
            phase_q <= phase_q + PW'(1);
    end

    assign stuck = (state_q == ST_MONITOR) && (phase_q == PW'(MAX_PHASE));
`else
    assign stuck = 1'b0;
`endif

    always_comb begin
        viol               = '0;
        viol[FLT_CODE]     = !lamp_valid(street_a_in) || !lamp_valid(street_b_in);
        viol[FLT_CONFLICT] = (street_a_in != LAMP_RED) && (street_b_in != LAMP_RED);
        viol[FLT_TRANS]    = bad_step(a_q, street_a_in) || bad_step(b_q, street_b_in);
        viol[FLT_STUCK]    = stuck;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        enter_fault = 1'b0;
        case (state_q)
            ST_INIT:    if (both_red) state_d = ST_MONITOR;
            ST_MONITOR: if (|viol) begin
                            state_d     = ST_FAULT;
                            enter_fault = 1'b1;
                        end
            ST_FAULT:   if (fault_clr && both_red) state_d = ST_MONITOR;
            default:    state_d = ST_INIT;
        endcase
    end

    assign pass = (state_q == ST_MONITOR) && (state_d == ST_MONITOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= LAMP_RED;
            b_q        <= LAMP_RED;
            a_lamp_q   <= LAMP_RED;
            b_lamp_q   <= LAMP_RED;
            a_pri_q    <= 1'b0;
            b_pri_q    <= 1'b0;
            fault_code <= '0;
        end else begin
            a_q <= street_a_in;
            b_q <= street_b_in;
            // Anything other than a clean MONITOR cycle parks the lamp registers at RED/RED.
            a_lamp_q <= pass ? street_a_in     : LAMP_RED;
            b_lamp_q <= pass ? street_b_in     : LAMP_RED;
            a_pri_q  <= pass ? street_a_pri_in : 1'b0;
            b_pri_q  <= pass ? street_b_pri_in : 1'b0;
            if (enter_fault)
                fault_code <= viol;
            else if (state_q == ST_FAULT && state_d == ST_MONITOR)
                fault_code <= '0;
        end
    end

    tsm_flash_gen #(.FLASH_CYC(FLASH_CYC)) u_flash (
        .clk      (clk),
        .rst      (rst),
        .restart  (enter_fault),
        .flash_on (flash_on)
    );

    // The FAULT override is a mux on registered state, so the violating code never shows.
    assign fault             = (state_q == ST_FAULT);
    assign street_a          = fault ? (flash_on ? LAMP_YELLOW : LAMP_OFF) : a_lamp_q;
    assign street_b          = fault ? (flash_on ? LAMP_YELLOW : LAMP_OFF) : b_lamp_q;
    assign street_a_pri_lamp = fault ? 1'b0 : a_pri_q;
    assign street_b_pri_lamp = fault ? 1'b0 : b_pri_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Directed and randomized bench for traffic_safety_monitor against a behavioural lamp-rule model.
module tb_traffic_safety_monitor;

    localparam int MAX_PHASE = 64;
    localparam int FLASH_CYC = 8;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a_in = G, b_in = R;
    logic       ap_in = 1'b0, bp_in = 1'b0, clr = 1'b0;
    logic [2:0] street_a, street_b;
    logic       a_pri, b_pri, fault;
    logic [3:0] fault_code;

    int checks = 0;
    int failures = 0;

    traffic_safety_monitor #(.MAX_PHASE(MAX_PHASE), .FLASH_CYC(FLASH_CYC)) dut (
        .clk               (clk),
        .rst               (rst),
        .street_a_in       (a_in),
        .street_a_pri_in   (ap_in),
        .street_b_in       (b_in),
        .street_b_pri_in   (bp_in),
        .fault_clr         (clr),
        .street_a          (street_a),
        .street_a_pri_lamp (a_pri),
        .street_b          (street_b),
        .street_b_pri_lamp (b_pri),
        .fault             (fault),
        .fault_code        (fault_code)
    );

    always #5 clk = ~clk;

    // Model: IDLE waits for red/red, RUN passes lamps through, TRIP flashes.
    typedef enum int { M_IDLE, M_RUN, M_TRIP } mode_e;
    mode_e      m_mode;
    logic [2:0] m_pa, m_pb, m_oa, m_ob;
    logic       m_opa, m_opb;
    logic [3:0] m_code;
    int         m_since, m_run;

    function automatic bit ok(input logic [2:0] c);
        return c == R || c == Y || c == G;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            R:       return G;
            G:       return Y;
            Y:       return R;
            default: return R;
        endcase
    endfunction

    function automatic bit illegal(input logic [2:0] p, input logic [2:0] c);
        return ok(p) && ok(c) && p != c && c != succ(p);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pa = R; m_pb = R; m_oa = R; m_ob = R;
        m_opa = 0; m_opb = 0; m_code = 0; m_since = 0; m_run = 0;
    endtask

    task automatic model_edge();
        logic [3:0] v;
        bit both_red;
        both_red = (a_in == R) && (b_in == R);
        case (m_mode)
            M_IDLE: begin
                m_oa = R; m_ob = R; m_opa = 0; m_opb = 0;
                if (both_red) begin m_mode = M_RUN; m_run = 0; end
            end
            M_RUN: begin
                v = 4'b0000;
                v[0] = !ok(a_in) || !ok(b_in);
                v[1] = (a_in != R) && (b_in != R);
                v[2] = illegal(m_pa, a_in) || illegal(m_pb, b_in);
`ifdef TSM_STUCK_CHECK_EN
                v[3] = (m_run >= MAX_PHASE);
`endif
                if (v != 0) begin
                    m_mode = M_TRIP; m_code = v; m_since = 0;
                end else begin
                    m_oa = a_in; m_ob = b_in; m_opa = ap_in; m_opb = bp_in;
                    if (a_in != m_pa || b_in != m_pb) m_run = 0;
                    else m_run++;
                end
            end
            M_TRIP: begin
                m_since++;
                if (clr && both_red) begin
                    m_mode = M_RUN; m_code = 0; m_run = 0;
                    m_oa = R; m_ob = R; m_opa = 0; m_opb = 0;
                end
            end
            default: ;
        endcase
        m_pa = a_in; m_pb = b_in;
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_l, obs_l;
        logic [2:0] fl;
        fl = ((m_since / FLASH_CYC) % 2 == 0) ? Y : OFF;
        exp_l = (m_mode == M_TRIP) ? {fl, 1'b0, fl, 1'b0} : {m_oa, m_opa, m_ob, m_opb};
        obs_l = {street_a, a_pri, street_b, b_pri};
        checks++;
        assert (obs_l === exp_l) else begin
            failures++;
            $error("FAIL %s lamps observed=%b expected=%b", tag, obs_l, exp_l);
        end
        checks++;
        assert (fault === (m_mode == M_TRIP)) else begin
            failures++;
            $error("FAIL %s fault observed=%b expected=%b", tag, fault, m_mode == M_TRIP);
        end
        checks++;
        assert (fault_code === m_code) else begin
            failures++;
            $error("FAIL %s fault_code observed=%b expected=%b", tag, fault_code, m_code);
        end
    endtask

    // Called at a negedge: drive, clock, update model, check at the next negedge.
    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic c, input string tag);
        a_in = a; b_in = b; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        logic [2:0] ra, rb;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset");
        rst = 1'b0;

        repeat (3) step(G, R, 0, "init_hold");
        step(R, R, 0, "init_exit");
        step(G, R, 0, "mon_green");
        step(Y, R, 0, "mon_yellow");
        step(R, R, 0, "mon_red");
        step(G, R, 0, "mon_green2");
        step(R, R, 0, "trans_g_r");
        step(R, R, 1, "clear1");
        step(G, R, 0, "pre_conflict");
        step(G, G, 0, "conflict");
        step(R, R, 1, "clear2");
        step(R, R, 0, "pre_code");
        step(3'b011, G, 0, "code_conflict");
        repeat (20) step(G, R, 1, "clr_ignored");
        step(R, R, 1, "clear3");
        repeat (70) step(G, R, 0, "stuck_hold");
        step(R, R, 1, "clear4");
        step(Y, R, 0, "r_to_y");
        repeat (5) step(R, R, 0, "flash");

        // Asynchronous reset between edges, checked before any clock edge.
        #2 rst = 1'b1;
        #1 model_reset();
        check("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(R, R, 0, "rst_init_exit");

        ra = R; rb = R;
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)       ;
            else if (r < 60)  ra = succ(ra);
            else if (r < 80)  rb = succ(rb);
            else if (r < 85)  ra = 3'($urandom_range(0, 7));
            else if (r < 90)  rb = 3'($urandom_range(0, 7));
            else begin ra = R; rb = R; end
            ap_in = 1'($urandom_range(0, 1));
            bp_in = 1'($urandom_range(0, 1));
            if (m_mode == M_TRIP && $urandom_range(0, 5) == 0) begin ra = R; rb = R; end
            step(ra, rb, 1'($urandom_range(0, 2) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_safety_monitor.md
# traffic_safety_monitor

Downstream safety stage for the traffic-light controller: consumes both streets' lamp codes and priority lamps and drives the physical lamp outputs. It checks every cycle for illegal codes, cross-street conflicts, illegal phase transitions and stuck phases. On any violation it latches a fault code and forces both streets to flashing yellow until an operator clear arrives while both inputs show red.

## Interface
- MAX_PHASE, 64: max cycles with no change on either street before a stuck fault.
- FLASH_CYC, 8: cycles per half-period of the fault flash.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- street_a_in  in  3  controller lamp code, street A.
- street_a_pri_in  in  1  controller priority lamp, street A.
- street_b_in  in  3  controller lamp code, street B.
- street_b_pri_in  in  1  controller priority lamp, street B.
- fault_clr  in  1  operator fault clear, level-sampled.
- street_a  out  3  lamp drive, street A.
- street_a_pri_lamp  out  1  priority lamp drive, street A.
- street_b  out  3  lamp drive, street B.
- street_b_pri_lamp  out  1  priority lamp drive, street B.
- fault  out  1  fault latched.
- fault_code  out  4  sticky fault cause bits.

## Operation
- Lamp encoding, one-hot: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000.
- Previous inputs are held in registers a_q and b_q. These update every cycle in all states.
- States: INIT, MONITOR, FAULT.
- INIT is the reset state. Outputs are forced to RED/RED with both priority lamps 0, and no checks run. Moves to MONITOR at the first edge where both inputs equal RED.
- MONITOR: outputs register the inputs (pass-through), including the priority lamps. The following checks run on the inputs at each edge:
  - bit0, illegal code: either input is not exactly one-hot (000, or more than one bit set).
  - bit1, conflict: neither input is RED.
  - bit2, illegal transition: a per-street change other than R→G, G→Y or Y→R (for example G→R, R→Y, Y→G).
  - bit3, stuck: the phase counter has reached MAX_PHASE.
- Phase counter: width $clog2(MAX_PHASE+1). Clears to 0 when either input differs from its q value, otherwise increments and saturates at MAX_PHASE. Clears on entering MONITOR.
- On any violation at edge k:
  - state becomes FAULT, fault=1, and fault_code = OR of all bits violated at k.
  - The outputs at k already show the flash pattern, so the violating code never reaches the lamps.
- FAULT:
  - street_a and street_b = YELLOW when flash_on, otherwise OFF. Priority lamps = 0.
  - flash_on is 1 for the first FLASH_CYC cycles after entry, then toggles every FLASH_CYC cycles.
  - fault_code is frozen; violations are not accumulated while in FAULT.
- Exit from FAULT: fault_clr=1 and both inputs RED at the same edge → MONITOR. At that edge fault=0, fault_code=0, outputs=RED/RED and the phase counter clears. fault_clr without both inputs RED is ignored. fault_clr in INIT or MONITOR has no effect.

## Timing
- Reset values: street_a=street_b=3'b100, both priority lamps 0, fault=0, fault_code=0, state INIT, counters 0, a_q=b_q=RED.
- rst acts immediately and asynchronously, including mid-FAULT or mid-flash. After release the block restarts in INIT.
- MONITOR latency is 1 cycle from input to output.
- Fault detection takes effect at the same edge that samples the violation (0 added latency).
- Stuck fault is reported at the edge where the counter equals MAX_PHASE, i.e. MAX_PHASE+1 edges with no change.
- Simultaneous violations at one edge set all corresponding bits.

## Configuration
- TSM_STUCK_CHECK_EN defined: the phase counter and bit3 stuck check are present.
- Not defined: no phase counter; fault_code[3] is tied to 0. All other behaviour is unchanged.

## Structure
- Shared package traffic_pkg holds:
  - lamp code constants LAMP_RED, LAMP_YELLOW, LAMP_GREEN, LAMP_OFF;
  - fault bit indices FLT_CODE, FLT_CONFLICT, FLT_TRANS, FLT_STUCK;
  - state encodings ST_INIT, ST_MONITOR, ST_FAULT.
- One sub-module, tsm_flash_gen:
  - FLASH_CYC counter with a synchronous restart input pulsed on FAULT entry;
  - outputs flash_on.

## Test plan
- Reset release with inputs A=GREEN, B=RED → outputs stay RED/RED in INIT. Both inputs RED at edge k → MONITOR; A=GREEN at k+1 appears on street_a at k+2.
- In MONITOR, A: G→Y→R with B RED → no fault. A: G→R directly → fault=1, fault_code=4'b0100, outputs YELLOW/YELLOW at the same edge.
- A=GREEN and B=GREEN at the same edge, from A=GREEN, B=RED → fault_code=4'b0010.
- A=3'b011 at the same edge as B leaving RED (R→G) → fault_code=4'b0011. Then:
  - outputs flash YELLOW for 8 cycles, OFF for 8, YELLOW again;
  - fault_clr=1 with A non-RED → stays in FAULT.
- Both inputs RED plus fault_clr=1 → fault=0, fault_code=0, outputs RED/RED. Then hold A=GREEN, B=RED unchanged → fault_code=4'b1000 at the 65th edge with no change (macro defined); no fault when the macro is undefined.
- Assert rst mid-flash (asynchronously, between edges) → outputs RED/RED, fault=0 and fault_code=0 immediately, with no clock edge.
